// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: round-robin sharing of one transparent D-latch register.
// Optional readback compare of latch Q enabled by LATCH_READBACK_CHECK_EN.
module latch_bank_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CNT_W     = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
`ifdef LATCH_READBACK_CHECK_EN
  input  logic [DATA_W-1:0]         lat_q_in,
  output logic                      err_out,
`endif
  output logic [NUM_REQ-1:0]        ack_out,
  output logic [DATA_W-1:0]         lat_d_out,
  output logic                      lat_en_out,
  output logic                      busy_out,
  output logic [2:0]                grant_id_out
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    OPEN,
    HOLD,
    ACK
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [2:0]       LAST_ID  = 3'(NUM_REQ - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [2:0]       ptr;
  logic [2:0]       ptr_n;
  logic [2:0]       win;
  logic             found;
  logic [3:0]       idx;
  logic [7:0]       req_pad;

  assign req_pad = 8'(req_in);

  // first requesting index at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = 4'(ptr) + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (!found && req_pad[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = SETUP;
          cnt_n   = SETUP_LD;
          ptr_n   = (win == LAST_ID) ? 3'd0 : win + 3'd1;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = OPEN;
          cnt_n   = OPEN_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      OPEN: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = HOLD_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) state_n = ACK;
        else cnt_n = cnt - 1'b1;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // outputs are registered from the next state so they settle with it
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      cnt          <= '0;
      ptr          <= '0;
      lat_en_out   <= 1'b0;
      lat_d_out    <= '0;
      ack_out      <= '0;
      busy_out     <= 1'b0;
      grant_id_out <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ptr        <= ptr_n;
      lat_en_out <= (state_n == OPEN);
      busy_out   <= (state_n != IDLE);
      ack_out    <= (state_n == ACK) ?
                    (NUM_REQ'(1) << grant_id_out) : '0;
      if (state == IDLE && found) begin
        lat_d_out    <= data_in[int'(win)*DATA_W +: DATA_W];
        grant_id_out <= win;
      end
    end
  end

`ifdef LATCH_READBACK_CHECK_EN
  // Q is settled during HOLD, so compare as ACK is entered
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      err_out <= 1'b0;
    end else if (state_n == ACK && lat_q_in != lat_d_out) begin
      err_out <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// tb_latch_bank_arbiter: directed + randomized check of latch_bank_arbiter
// against a transaction-timeline model.
module tb_latch_bank_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int S     = 1;
  localparam int O     = 2;
  localparam int H     = 1;
  localparam int T_ACK = S + O + H;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NR-1:0]  req   = '0;
  logic [NR*DW-1:0] data = '0;
  logic [NR-1:0]  ack;
  logic [DW-1:0]  lat_d;
  logic           lat_en;
  logic           busy;
  logic [2:0]     gid;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // model: time since grant of the active transaction
  bit            m_act = 1'b0;
  int            m_t   = 0;
  int            m_gid = 0;
  int            m_ptr = 0;
  logic [DW-1:0] m_d   = '0;
  int            m_wait [NR];

`ifdef LATCH_READBACK_CHECK_EN
  logic [DW-1:0] lat_q = '0;
  logic          err;
  always @(lat_en or lat_d) if (lat_en) lat_q = lat_d;
`endif

  latch_bank_arbiter dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .req_in       (req),
    .data_in      (data),
`ifdef LATCH_READBACK_CHECK_EN
    .lat_q_in     (lat_q),
    .err_out      (err),
`endif
    .ack_out      (ack),
    .lat_d_out    (lat_d),
    .lat_en_out   (lat_en),
    .busy_out     (busy),
    .grant_id_out (gid)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(logic [NR-1:0] r, int p);
    for (int k = 0; k < NR; k++)
      if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_act <= 1'b0;
      m_t   <= 0;
      m_gid <= 0;
      m_ptr <= 0;
      m_d   <= '0;
      for (int i = 0; i < NR; i++) m_wait[i] <= 0;
    end else if (!m_act) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_act <= 1'b1;
        m_t   <= 0;
        m_gid <= w;
        m_d   <= data[w*DW +: DW];
        m_ptr <= (w + 1) % NR;
        for (int i = 0; i < NR; i++) begin
          if (i == w || !req[i]) begin
            m_wait[i] <= 0;
          end else begin
            m_wait[i] <= m_wait[i] + 1;
            check($sformatf("no_starve_%0d", i), 32'(m_wait[i] + 1 < NR), 1);
          end
        end
      end
    end else if (m_t == T_ACK) begin
      m_act <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 32'(busy), 32'(m_act));
      check("lat_en", 32'(lat_en), 32'(m_act && m_t >= S && m_t < S + O));
      check("lat_d", 32'(lat_d), 32'(m_d));
      check("grant_id", 32'(gid), 32'(m_gid));
      check("ack", 32'(ack), (m_act && m_t == T_ACK) ? (32'd1 << m_gid) : 32'd0);
`ifdef LATCH_READBACK_CHECK_EN
      check("err", 32'(err), 0);
`endif
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_ack(int exp, string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (ack == '0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(ack != '0), 1);
    if (ack != '0) begin
      check({tag, "_ack"}, 32'(ack), 32'd1 << exp);
      check({tag, "_gid"}, 32'(gid), 32'(exp));
      check({tag, "_d"}, 32'(lat_d), 32'((exp + 1) * 16));
    end
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_en", 32'(lat_en), 0);
    check("rst_d", 32'(lat_d), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_gid", 32'(gid), 0);

    #1 req = 4'b0001;
    data[7:0] = 8'hA5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("sw_en_c%0d", k), 32'(lat_en), 32'(k == 2 || k == 3));
      check($sformatf("sw_d_c%0d", k), 32'(lat_d), 32'hA5);
      check($sformatf("sw_ack_c%0d", k), 32'(ack), (k == 5) ? 1 : 0);
      check($sformatf("sw_busy_c%0d", k), 32'(busy), 32'(k <= 5));
      #1;
      if (k == 1) req = '0;
      if (k == 2) data[7:0] = 8'h5A;
    end

    do_reset();
    req  = 4'b1111;
    data = {8'h40, 8'h30, 8'h20, 8'h10};
    wait_ack(0, "rr0");
    wait_ack(1, "rr1");
    wait_ack(2, "rr2");
    wait_ack(3, "rr3");
    wait_ack(0, "rr4");
    #1 req = 4'b0100;
    wait_ack(2, "wrap2");
    #1 req = 4'b0101;
    wait_ack(0, "wrap0");
    wait_ack(2, "wrap2b");

    #1 req = 4'b0010;
    n = 0;
    while (!lat_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_open_seen", 32'(lat_en), 1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_en", 32'(lat_en), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_ack", 32'(ack), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    req = 4'b1111;
    wait_ack(0, "ar_first");

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 2) == 0) data = 32'($urandom);
    end

    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
